// File: rtl/logic_gate_unit_if.sv
// logic_gate_unit_if: stream bundle for the logic_gate_unit stage.
//   Producer side : in_valid, in_ready, op, acc_mode, a, b
//   Consumer side : out_valid, out_ready, s, zero, ones, parity
//   master modport: the environment that drives operands and accepts results
//   slave modport : the logic unit itself
interface logic_gate_unit_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic             acc_mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             zero;
  logic             ones;
  logic             parity;

  modport master (
    output in_valid, op, acc_mode, a, b, out_ready,
    input  in_ready, out_valid, s, zero, ones, parity
  );

  modport slave (
    input  in_valid, op, acc_mode, a, b, out_ready,
    output in_ready, out_valid, s, zero, ones, parity
  );
endinterface

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered WIDTH-bit bitwise logic stage, one beat deep.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : logic_gate_unit_if.slave
//           in_valid/in_ready handshake carries op, acc_mode, a, b;
//           out_valid/out_ready handshake carries s and the zero/ones/parity flags.
// The left operand is either a or the internal accumulator, which always
// captures the last accepted result so successive beats can chain reductions.
module logic_gate_unit #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  logic_gate_unit_if.slave    bus
);

  // Bitwise operation selected by op.
  function automatic logic [WIDTH-1:0] gate_f(
    input logic [2:0]       op_i,
    input logic [WIDTH-1:0] l_i,
    input logic [WIDTH-1:0] r_i
  );
    logic [WIDTH-1:0] res;
    case (op_i)
      3'd0:    res = l_i & r_i;
      3'd1:    res = l_i | r_i;
      3'd2:    res = l_i ^ r_i;
      3'd3:    res = ~(l_i & r_i);
      3'd4:    res = ~(l_i | r_i);
      3'd5:    res = ~(l_i ^ r_i);
      3'd6:    res = l_i & ~r_i;
      3'd7:    res = l_i;
      default: res = l_i;
    endcase
    return res;
  endfunction

  // Odd-parity indicator: 1 when the word has an odd number of ones.
  function automatic logic parity_f(input logic [WIDTH-1:0] v_i);
    return ^v_i;
  endfunction

  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic             parity_q, parity_d;

  logic             in_ready_s;
  logic             accept_s;
  logic [WIDTH-1:0] left_s;
  logic [WIDTH-1:0] result_s;

  // Handshake decode, operand select and next-state computation.
  always_comb begin
    s_d         = s_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    zero_d      = zero_q;
    ones_d      = ones_q;
    parity_d    = parity_q;

    // Space is available when the output slot is empty or drains this cycle.
    in_ready_s = !out_valid_q || bus.out_ready;
    accept_s   = bus.in_valid && in_ready_s;
    left_s     = bus.acc_mode ? acc_q : bus.a;
    result_s   = gate_f(bus.op, left_s, bus.b);

    if (accept_s) begin
      // A new beat wins over a simultaneous drain, keeping out_valid high.
      s_d         = result_s;
      acc_d       = result_s;
      out_valid_d = 1'b1;
      zero_d      = (result_s == {WIDTH{1'b0}});
      ones_d      = &result_s;
      parity_d    = parity_f(result_s);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers; reset drops any pending result and clears the accumulator.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q         <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      ones_q      <= 1'b0;
      parity_q    <= 1'b0;
    end else begin
      s_q         <= s_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      zero_q      <= zero_d;
      ones_q      <= ones_d;
      parity_q    <= parity_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.zero      = zero_q;
  assign bus.ones      = ones_q;
  assign bus.parity    = parity_q;

endmodule
